datapath_mem_seq: RTL and testbench
===================================

Name: datapath_mem_seq

Overview:
Parametrised successor to the current register-file/ALU/memory datapath. Tri-state bus steering (BtoD/FtoD/FtoA/OuttoD) and hand-sequenced write/read enables are replaced by an internal op sequencer with a start/busy/done handshake. Register count, word width, memory depth and memory latency are all configurable. The block sits beneath the future control unit, which issues one ALU, LOAD or STORE op at a time.

Parameters:
WIDTH, 64, datapath and memory word width
NREGS, 32, register count (power of 2); register NREGS-1 is hard zero
DEPTH, 256, data memory words (power of 2)
MEM_LAT, 1, memory access wait cycles (>=1)

Ports:
clock  in  1  rising-edge clock
reset  in  1  asynchronous active-high reset
start  in  1  op request, sampled in IDLE only
op  in  2  00 ALU, 01 LOAD, 10 STORE, 11 reserved (treated as ALU, no writeback)
SA  in  $clog2(NREGS)  A read select
SB  in  $clog2(NREGS)  B read select
DA  in  $clog2(NREGS)  writeback destination
FS  in  5  ALU function select
Cin  in  1  ALU carry in
selbork  in  1  1: ALU B operand = k, 0: B operand = R[SB]
k  in  WIDTH  immediate
busy  out  1  high from accept through final cycle
done  out  1  one-cycle completion pulse
D  out  WIDTH  last writeback value (ALU/LOAD) or store data (STORE)
status  out  4  {V,C,N,Z} of last ALU evaluation

Behaviour:
- Reset (async): state IDLE; busy=0, done=0, D=0, status=0; all registers 0; memory contents not cleared.
- ALU: F = f(A', B'), where A' = FS[0] ? ~A : A and B' = FS[1] ? ~B : B. FS[4:2]: 000 AND, 001 OR, 010 ADD (A'+B'+Cin), 011 XOR, 100 A'<<B'[$clog2(WIDTH)-1:0], 101 logical right shift by the same amount, others yield 0.
- Status flags: C = carry out and V = signed overflow, meaningful for ADD, 0 for other functions. N = F[WIDTH-1]. Z = (F==0).
- R[NREGS-1] always reads 0. Writes to it are discarded silently, with done still pulsed.
- FSM states: IDLE, EXEC, MEM_WAIT, WB.
- IDLE: start=1 at an edge captures op, SA, SB, DA, FS, Cin, selbork and k; busy=1; next state EXEC. Inputs are don't-care after capture.
- EXEC (one cycle): F and status are registered.
  - ALU: go to WB.
  - LOAD/STORE: address = F[$clog2(DEPTH)-1:0] (silent wrap modulo DEPTH); store data = R[SB]; load wait counter with MEM_LAT; go to MEM_WAIT.
- MEM_WAIT: counter decrements each edge. On the edge where it reaches 0:
  - STORE writes mem[addr].
  - LOAD latches mem[addr].
  - Go to WB.
- WB (one cycle):
  - ALU/LOAD: R[DA] written and D updated at the end of this cycle.
  - STORE: D = store data.
  - done=1 and busy=0 in the following cycle; state returns to IDLE.
- Latency from start edge to done high: ALU 3 edges; LOAD/STORE 3+MEM_LAT edges.
- Back-to-back ops: a new start is accepted while done=1 (state is IDLE).
- start while busy: ignored, no queuing.
- Register reads during EXEC use pre-writeback values; there is no read-during-write hazard because only one op is in flight.
- Reset mid-op: immediate abort; no done pulse; a pending memory write is dropped.

Optional Feature:
DBG_PORT_EN
- Defined: adds input dbg_sel [$clog2(NREGS)-1:0] and output dbg_data [WIDTH-1:0] = R[dbg_sel], combinational, no side effects. Replaces the fixed r0..r7 taps.
- Undefined: neither port exists.
- No other behaviour changes.

Decomposition:
- datapath_pkg: op codes, FS[4:2] function codes, FSM state enum, status bit indices (V=3, C=2, N=1, Z=0).
- One sub-module, alu_param (WIDTH): combinational, ports A, B, FS, Cin, F, status.
- Register file and memory stay inline.

Test Plan:
1. Reset; ALU SA=31, selbork=1, k=7, FS=00100, DA=3 -> done 3 edges after start; R3=7, D=7, status=0000.
2. STORE SA=31, selbork=1, k=8, FS=00100, SB=3, MEM_LAT=1 -> done after 4 edges; mem[8]=7; D=7; registers unchanged.
3. LOAD SA=31, k=8, FS=00100, DA=2 -> R2=7, D=7, done after 4 edges. Repeat with MEM_LAT=3 -> done after 6 edges.
4. ALU SA=3, selbork=1, k=7, FS=01010, Cin=1 (subtract) -> F=0, status Z=1, C=1, N=0, V=0. Then k=8 -> F=all ones, N=1, C=0.
5. Pulse start for a second op while busy -> ignored: exactly one done pulse, only the first op's effect. ALU with DA=31 -> done pulsed; R31 still reads 0.
6. Assert reset during MEM_WAIT of a STORE to addr 9 -> busy=0 immediately, no done pulse, mem[9] unchanged, all registers 0. Address k=DEPTH+5 -> access wraps to word 5.

Source files
------------

// File: rtl/datapath_pkg.sv
// datapath_pkg
// Shared definitions for the parametrised register-file / ALU / memory
// datapath: op codes, ALU function codes (FS[4:2]), sequencer state
// encoding and bit positions inside the 4-bit {V,C,N,Z} status word.
// No ports (package).

package datapath_pkg;

    // Op codes presented on 'op'; 2'b11 is reserved and runs as an ALU
    // evaluation without writeback.
    localparam logic [1:0] OP_ALU   = 2'b00;
    localparam logic [1:0] OP_LOAD  = 2'b01;
    localparam logic [1:0] OP_STORE = 2'b10;

    // ALU function codes carried in FS[4:2].
    localparam logic [2:0] FN_AND = 3'b000;
    localparam logic [2:0] FN_OR  = 3'b001;
    localparam logic [2:0] FN_ADD = 3'b010;
    localparam logic [2:0] FN_XOR = 3'b011;
    localparam logic [2:0] FN_SHL = 3'b100;
    localparam logic [2:0] FN_SHR = 3'b101;

    // Op sequencer states.
    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_EXEC     = 2'd1,
        S_MEM_WAIT = 2'd2,
        S_WB       = 2'd3
    } state_t;

    // Bit positions inside status = {V,C,N,Z}.
    localparam int ST_V = 3;
    localparam int ST_C = 2;
    localparam int ST_N = 1;
    localparam int ST_Z = 0;

endpackage

// File: rtl/alu_param.sv
// alu_param
// Combinational ALU of parametrised width.
//   A, B    : operands (each optionally inverted by FS[0] / FS[1])
//   FS      : function select; FS[4:2] picks AND/OR/ADD/XOR/SHL/SHR
//   Cin     : carry in (ADD only)
//   F       : result
//   status  : {V,C,N,Z}; V and C are only non-zero for ADD

module alu_param
    import datapath_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [4:0]       FS,
    input  logic             Cin,
    output logic [WIDTH-1:0] F,
    output logic [3:0]       status
);

    localparam int SHW = $clog2(WIDTH);

    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_b;
    logic [WIDTH:0]   w_sum;

    assign w_a   = FS[0] ? ~A : A;
    assign w_b   = FS[1] ? ~B : B;
    // One extra bit so the carry out falls out of the same adder.
    assign w_sum = {1'b0, w_a} + {1'b0, w_b} + {{WIDTH{1'b0}}, Cin};

    always_comb begin
        F      = '0;
        status = '0;
        case (FS[4:2])
            FN_AND: F = w_a & w_b;
            FN_OR:  F = w_a | w_b;
            FN_ADD: begin
                F            = w_sum[WIDTH-1:0];
                status[ST_C] = w_sum[WIDTH];
                // Overflow: both operands share a sign the result lacks.
                status[ST_V] = (w_a[WIDTH-1] == w_b[WIDTH-1]) &&
                               (w_sum[WIDTH-1] != w_a[WIDTH-1]);
            end
            FN_XOR: F = w_a ^ w_b;
            FN_SHL: F = w_a << w_b[SHW-1:0];
            FN_SHR: F = w_a >> w_b[SHW-1:0];
            default: F = '0;
        endcase
        status[ST_N] = F[WIDTH-1];
        status[ST_Z] = (F == '0);
    end

endmodule

// File: rtl/datapath_mem_seq.sv
// datapath_mem_seq
// Register file + ALU + data memory with an internal op sequencer.
// One ALU, LOAD or STORE op is accepted at a time through start/busy/done.
// Sequencer states: IDLE -> EXEC -> (MEM_WAIT x MEM_LAT) -> WB -> IDLE.
//
// Ports:
//   clock, reset     : rising-edge clock, asynchronous active-high reset
//   start            : op request, sampled only in IDLE
//   op               : 00 ALU, 01 LOAD, 10 STORE, 11 reserved (ALU, no writeback)
//   SA, SB, DA       : A read select, B read select, writeback destination
//   FS, Cin, selbork : ALU function, carry in, B-operand select (1: k)
//   k                : immediate
//   busy, done       : busy from accept through WB; done is a 1-cycle pulse
//   D                : last writeback value, or store data for STORE
//   status           : {V,C,N,Z} of the last ALU evaluation
//
// Valid/ready semantics: the block is "ready" exactly when busy=0; an op is
// transferred on the rising edge where start=1 and the sequencer is IDLE.
// start while busy is dropped, never queued. done=1 marks the cycle after
// WB, which is already IDLE, so a new start may be issued in that cycle.
//
// Optional build macro DBG_PORT_EN adds dbg_sel/dbg_data, a combinational
// register-file peek with no side effects.

module datapath_mem_seq
    import datapath_pkg::*;
#(
    parameter int WIDTH   = 64,
    parameter int NREGS   = 32,
    parameter int DEPTH   = 256,
    parameter int MEM_LAT = 1
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     start,
    input  logic [1:0]               op,
    input  logic [$clog2(NREGS)-1:0] SA,
    input  logic [$clog2(NREGS)-1:0] SB,
    input  logic [$clog2(NREGS)-1:0] DA,
    input  logic [4:0]               FS,
    input  logic                     Cin,
    input  logic                     selbork,
    input  logic [WIDTH-1:0]         k,
    output logic                     busy,
    output logic                     done,
    output logic [WIDTH-1:0]         D,
`ifdef DBG_PORT_EN
    input  logic [$clog2(NREGS)-1:0] dbg_sel,
    output logic [WIDTH-1:0]         dbg_data,
`endif
    output logic [3:0]               status
);

    localparam int RW = $clog2(NREGS);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = (MEM_LAT < 2) ? 1 : $clog2(MEM_LAT + 1);
    localparam logic [RW-1:0] ZREG = RW'(NREGS - 1);

    // Sequencer state (kept in a plain register so checkers can bind to it).
    state_t            r_state;

    // Captured op.
    logic [1:0]        r_op;
    logic [RW-1:0]     r_sa;
    logic [RW-1:0]     r_sb;
    logic [RW-1:0]     r_da;
    logic [4:0]        r_fs;
    logic              r_cin;
    logic              r_selbork;
    logic [WIDTH-1:0]  r_k;

    // Execution results.
    logic [WIDTH-1:0]  r_f;
    logic [AW-1:0]     r_addr;
    logic [WIDTH-1:0]  r_sdata;
    logic [WIDTH-1:0]  r_ld;
    logic [CW-1:0]     r_cnt;

    // Registered outputs.
    logic              r_busy;
    logic              r_done;
    logic [WIDTH-1:0]  r_d;
    logic [3:0]        r_status;

    logic [WIDTH-1:0]  r_regs [NREGS];
    logic [WIDTH-1:0]  r_mem  [DEPTH];

    logic [WIDTH-1:0]  w_ra;
    logic [WIDTH-1:0]  w_rb;
    logic [WIDTH-1:0]  w_alu_b;
    logic [WIDTH-1:0]  w_f;
    logic [3:0]        w_status;
    logic              w_mem_fire;
    logic              w_mem_we;

    // The top register is never written, but the read is forced to zero as
    // well so the hard-zero property does not rely on reset.
    assign w_ra    = (r_sa == ZREG) ? '0 : r_regs[r_sa];
    assign w_rb    = (r_sb == ZREG) ? '0 : r_regs[r_sb];
    assign w_alu_b = r_selbork ? r_k : w_rb;

    alu_param #(.WIDTH(WIDTH)) u_alu (
        .A      (w_ra),
        .B      (w_alu_b),
        .FS     (r_fs),
        .Cin    (r_cin),
        .F      (w_f),
        .status (w_status)
    );

    // The memory access happens on the edge where the wait counter hits 0.
    assign w_mem_fire = (r_state == S_MEM_WAIT) && (r_cnt == CW'(1));
    assign w_mem_we   = w_mem_fire && (r_op == OP_STORE);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_op      <= OP_ALU;
            r_sa      <= '0;
            r_sb      <= '0;
            r_da      <= '0;
            r_fs      <= '0;
            r_cin     <= 1'b0;
            r_selbork <= 1'b0;
            r_k       <= '0;
            r_f       <= '0;
            r_addr    <= '0;
            r_sdata   <= '0;
            r_ld      <= '0;
            r_cnt     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_d       <= '0;
            r_status  <= '0;
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_op      <= op;
                        r_sa      <= SA;
                        r_sb      <= SB;
                        r_da      <= DA;
                        r_fs      <= FS;
                        r_cin     <= Cin;
                        r_selbork <= selbork;
                        r_k       <= k;
                        r_busy    <= 1'b1;
                        r_state   <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    r_f      <= w_f;
                    r_status <= w_status;
                    r_addr   <= w_f[AW-1:0];
                    r_sdata  <= w_rb;
                    r_cnt    <= CW'(MEM_LAT);
                    if (r_op == OP_LOAD || r_op == OP_STORE) begin
                        r_state <= S_MEM_WAIT;
                    end else begin
                        r_state <= S_WB;
                    end
                end
                S_MEM_WAIT: begin
                    r_cnt <= r_cnt - CW'(1);
                    if (w_mem_fire) begin
                        if (r_op == OP_LOAD) begin
                            r_ld <= r_mem[r_addr];
                        end
                        r_state <= S_WB;
                    end
                end
                S_WB: begin
                    case (r_op)
                        OP_ALU: begin
                            r_d <= r_f;
                            if (r_da != ZREG) begin
                                r_regs[r_da] <= r_f;
                            end
                        end
                        OP_LOAD: begin
                            r_d <= r_ld;
                            if (r_da != ZREG) begin
                                r_regs[r_da] <= r_ld;
                            end
                        end
                        OP_STORE: r_d <= r_sdata;
                        default: ;  // reserved op: status only
                    endcase
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Memory has no reset. A reset mid-op forces IDLE asynchronously, so
    // w_mem_we is already low at the next edge and the write is dropped.
    always_ff @(posedge clock) begin
        if (w_mem_we) begin
            r_mem[r_addr] <= r_sdata;
        end
    end

    assign busy   = r_busy;
    assign done   = r_done;
    assign D      = r_d;
    assign status = r_status;

`ifdef DBG_PORT_EN
    assign dbg_data = (dbg_sel == ZREG) ? '0 : r_regs[dbg_sel];
`endif

endmodule

// File: tb/tb_datapath_mem_seq.sv
`timescale 1ns/1ps
module tb_datapath_mem_seq;

  localparam int WIDTH    = 64;
  localparam int NREGS    = 32;
  localparam int DEPTH    = 256;
  localparam int MEM_LAT  = 1;
  localparam int MEM_LAT3 = 3;
  localparam int RW       = 5;
  localparam int EW       = WIDTH + 4;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  longint unsigned cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // ---------------- DUT signals ----------------
  logic             start = 1'b0, start3 = 1'b0;
  logic [1:0]       op = '0;
  logic [RW-1:0]    sa = '0, sb = '0, da = '0;
  logic [4:0]       fs = '0;
  logic             cin = 1'b0, selbork = 1'b0;
  logic [WIDTH-1:0] k = '0;
  logic             busy, done, busy3, done3;
  logic [WIDTH-1:0] d_out, d3;
  logic [3:0]       status, status3;
`ifdef DBG_PORT_EN
  logic [RW-1:0]    dbg_sel = '0, dbg_sel3 = '0;
  logic [WIDTH-1:0] dbg_data, dbg_data3;
`endif

  datapath_mem_seq #(.WIDTH(WIDTH), .NREGS(NREGS), .DEPTH(DEPTH), .MEM_LAT(MEM_LAT)) dut (
    .clock(clock), .reset(reset), .start(start), .op(op), .SA(sa), .SB(sb), .DA(da),
    .FS(fs), .Cin(cin), .selbork(selbork), .k(k), .busy(busy), .done(done), .D(d_out),
`ifdef DBG_PORT_EN
    .dbg_sel(dbg_sel), .dbg_data(dbg_data),
`endif
    .status(status)
  );

  datapath_mem_seq #(.WIDTH(WIDTH), .NREGS(NREGS), .DEPTH(DEPTH), .MEM_LAT(MEM_LAT3)) dut3 (
    .clock(clock), .reset(reset), .start(start3), .op(op), .SA(sa), .SB(sb), .DA(da),
    .FS(fs), .Cin(cin), .selbork(selbork), .k(k), .busy(busy3), .done(done3), .D(d3),
`ifdef DBG_PORT_EN
    .dbg_sel(dbg_sel3), .dbg_data(dbg_data3),
`endif
    .status(status3)
  );

  // ---------------- counters / check helper ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  logic [WIDTH-1:0] m_regs [NREGS];
  logic [WIDTH-1:0] m_mem  [DEPTH];
  logic [WIDTH-1:0] m_d = '0;

  // Returns {V,C,N,Z, F}. Overflow is judged by whether the exact signed
  // sum still fits in WIDTH bits.
  function automatic logic [EW-1:0] model_alu(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                              input logic [4:0] f_s, input logic c_in);
    logic [WIDTH-1:0] ap, bp, f;
    logic [WIDTH:0]   u;
    logic [WIDTH+1:0] s;
    logic v, c;
    ap = f_s[0] ? ~a : a;
    bp = f_s[1] ? ~b : b;
    v = 1'b0;
    c = 1'b0;
    f = '0;
    case (f_s[4:2])
      3'd0: f = ap & bp;
      3'd1: f = ap | bp;
      3'd2: begin
        u = {1'b0, ap} + {1'b0, bp} + {{WIDTH{1'b0}}, c_in};
        f = u[WIDTH-1:0];
        c = u[WIDTH];
        s = {{2{ap[WIDTH-1]}}, ap} + {{2{bp[WIDTH-1]}}, bp} + {{(WIDTH+1){1'b0}}, c_in};
        v = (s != {{2{f[WIDTH-1]}}, f});
      end
      3'd3: f = ap ^ bp;
      3'd4: f = ap << bp[5:0];
      3'd5: f = ap >> bp[5:0];
      default: f = '0;
    endcase
    return {v, c, f[WIDTH-1], (f == '0), f};
  endfunction

  // ---------------- scoreboard ----------------
  logic [EW-1:0]   exp_q[$];
  int              lat_q[$];
  longint unsigned acc_q[$];

  always @(negedge clock) begin
    logic [EW-1:0] e;
    int l;
    longint unsigned a;
    if (!reset && done) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done: got done=1 with D=%h expected no completion (cycle %0d)", d_out, cyc);
      end else begin
        e = exp_q.pop_front();
        l = lat_q.pop_front();
        a = acc_q.pop_front();
        check("D", d_out, e[WIDTH-1:0]);
        check("status", {60'd0, status}, {60'd0, e[EW-1:WIDTH]});
        check("latency", 64'(cyc - a + 1), 64'(l));
      end
    end
  end

  // ---------------- driver ----------------
  // Called at a negedge; returns at the negedge where done is seen.
  task automatic issue(input logic [1:0] t_op, input logic [RW-1:0] t_sa, input logic [RW-1:0] t_sb,
                       input logic [RW-1:0] t_da, input logic [4:0] t_fs, input logic t_cin,
                       input logic t_sel, input logic [WIDTH-1:0] t_k, input bit poke);
    logic [WIDTH-1:0] a, b, f, val;
    logic [EW-1:0] r;
    int idx, t;
    a = m_regs[t_sa];
    b = t_sel ? t_k : m_regs[t_sb];
    r = model_alu(a, b, t_fs, t_cin);
    f = r[WIDTH-1:0];
    idx = int'(f % 64'(DEPTH));
    case (t_op)
      2'b00, 2'b01: begin
        val = (t_op == 2'b01) ? m_mem[idx] : f;
        m_d = val;
        if (t_da != RW'(NREGS - 1)) m_regs[t_da] = val;
      end
      2'b10: begin
        m_mem[idx] = m_regs[t_sb];
        m_d = m_regs[t_sb];
      end
      default: ;
    endcase
    exp_q.push_back({r[EW-1:WIDTH], m_d});
    lat_q.push_back((t_op == 2'b01 || t_op == 2'b10) ? 3 + MEM_LAT : 3);

    op = t_op; sa = t_sa; sb = t_sb; da = t_da; fs = t_fs; cin = t_cin; selbork = t_sel; k = t_k;
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    acc_q.push_back(cyc);
    @(negedge clock);
    check("busy_after_accept", {63'd0, busy}, 64'd1);
    if (poke) begin
      // A competing request while busy: must be dropped.
      op = 2'b00; sa = 5'd31; da = 5'd4; fs = 5'b00100; selbork = 1'b1; k = 64'hDEAD_BEEF;
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
    end
    t = 0;
    while (!done && t < 40) begin
      @(negedge clock);
      t++;
    end
    n_checks++;
    if (!done) begin
      n_fail++;
      $display("FAIL done_timeout: got no done within 40 cycles expected done (op %0d)", t_op);
    end else begin
      check("busy_at_done", {63'd0, busy}, 64'd0);
    end
  endtask

  // Directed op on the MEM_LAT=3 instance with an explicit expectation.
  task automatic run3(input logic [1:0] t_op, input logic [RW-1:0] t_sb, input logic [RW-1:0] t_da,
                      input logic [WIDTH-1:0] t_k, input logic [WIDTH-1:0] exp_d, input int exp_lat);
    longint unsigned acc;
    int t;
    op = t_op; sa = 5'd31; sb = t_sb; da = t_da; fs = 5'b00100; cin = 1'b0; selbork = 1'b1; k = t_k;
    start3 = 1'b1;
    @(posedge clock);
    #1;
    start3 = 1'b0;
    acc = cyc;
    t = 0;
    @(negedge clock);
    while (!done3 && t < 40) begin
      @(negedge clock);
      t++;
    end
    check("lat3_latency", 64'(cyc - acc + 1), 64'(exp_lat));
    check("lat3_D", d3, exp_d);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got simulation still running expected completion");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // ---------------- main sequence ----------------
  initial begin
    for (int i = 0; i < NREGS; i++) m_regs[i] = '0;

    repeat (3) @(negedge clock);
    check("reset_busy", {63'd0, busy}, 64'd0);
    check("reset_done", {63'd0, done}, 64'd0);
    check("reset_D", d_out, 64'd0);
    check("reset_status", {60'd0, status}, 64'd0);
    reset = 1'b0;
    @(negedge clock);

    // ALU immediate into R3, store to 8, load back into R2
    issue(2'b00, 5'd31, 5'd0, 5'd3, 5'b00100, 1'b0, 1'b1, 64'd7, 1'b0);
    issue(2'b10, 5'd31, 5'd3, 5'd0, 5'b00100, 1'b0, 1'b1, 64'd8, 1'b0);
    issue(2'b01, 5'd31, 5'd0, 5'd2, 5'b00100, 1'b0, 1'b1, 64'd8, 1'b0);
    // Subtract R3 - 7 (zero) and R3 - 8 (all ones)
    issue(2'b00, 5'd3, 5'd0, 5'd5, 5'b01010, 1'b1, 1'b1, 64'd7, 1'b0);
    issue(2'b00, 5'd3, 5'd0, 5'd5, 5'b01010, 1'b1, 1'b1, 64'd8, 1'b0);
    // Start while busy is ignored; write to the hard-zero register
    issue(2'b00, 5'd31, 5'd0, 5'd6, 5'b00100, 1'b0, 1'b1, 64'h1234, 1'b1);
    issue(2'b00, 5'd31, 5'd0, 5'd31, 5'b00100, 1'b0, 1'b1, 64'h55, 1'b0);
    issue(2'b00, 5'd31, 5'd0, 5'd7, 5'b00100, 1'b0, 1'b1, 64'd0, 1'b0);
    issue(2'b00, 5'd4, 5'd0, 5'd31, 5'b00100, 1'b0, 1'b1, 64'd0, 1'b0);

    // Fill the whole memory with random words
    for (int a = 0; a < DEPTH; a++) begin
      issue(2'b00, 5'd31, 5'd0, 5'd1, 5'b00100, 1'b0, 1'b1, {$urandom(), $urandom()}, 1'b0);
      issue(2'b10, 5'd31, 5'd1, 5'd0, 5'b00100, 1'b0, 1'b1, 64'(a), 1'b0);
    end

    // Address wrap: DEPTH+5 lands on word 5
    issue(2'b00, 5'd31, 5'd0, 5'd1, 5'b00100, 1'b0, 1'b1, {$urandom(), $urandom()}, 1'b0);
    issue(2'b10, 5'd31, 5'd1, 5'd0, 5'b00100, 1'b0, 1'b1, 64'(DEPTH + 5), 1'b0);
    issue(2'b01, 5'd31, 5'd0, 5'd6, 5'b00100, 1'b0, 1'b1, 64'd5, 1'b0);

    // Randomised ops
    for (int n = 0; n < 150; n++) begin
      logic [1:0] r_op;
      logic [WIDTH-1:0] r_k;
      r_op = 2'($urandom_range(0, 3));
      r_k  = ($urandom_range(0, 1) == 1) ? 64'($urandom_range(0, 600)) : {$urandom(), $urandom()};
      issue(r_op, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
            5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), r_k, 1'b0);
    end

    // Reset during MEM_WAIT of a STORE to address 9
    issue(2'b00, 5'd31, 5'd0, 5'd1, 5'b00100, 1'b0, 1'b1, ~m_mem[9], 1'b0);
    op = 2'b10; sa = 5'd31; sb = 5'd1; da = 5'd0; fs = 5'b00100; cin = 1'b0; selbork = 1'b1; k = 64'd9;
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    #1;
    check("abort_busy", {63'd0, busy}, 64'd0);
    check("abort_done", {63'd0, done}, 64'd0);
    check("abort_D", d_out, 64'd0);
    check("abort_status", {60'd0, status}, 64'd0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < NREGS; i++) m_regs[i] = '0;
    m_d = '0;
    repeat (3) @(negedge clock);
    for (int i = 0; i < NREGS - 1; i++) begin
      issue(2'b00, 5'(i), 5'd0, 5'd31, 5'b00100, 1'b0, 1'b1, 64'd0, 1'b0);
    end
    issue(2'b01, 5'd31, 5'd0, 5'd2, 5'b00100, 1'b0, 1'b1, 64'd9, 1'b0);

    // MEM_LAT=3 instance: ALU 3 edges, STORE/LOAD 6 edges
    run3(2'b00, 5'd0, 5'd3, 64'd7, 64'd7, 3);
    run3(2'b10, 5'd3, 5'd0, 64'd8, 64'd7, 3 + MEM_LAT3);
    run3(2'b01, 5'd0, 5'd2, 64'd8, 64'd7, 3 + MEM_LAT3);

    repeat (5) @(negedge clock);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d outstanding expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
